// File: rtl/pong_score_fsm.sv
`default_nettype none
// ============================================================================
// pong_score_fsm : miss detection, scoring and serve/point/game-over control.
// Optional feature macro: PONG_AUTO_SERVE_EN (timed automatic re-serve).
// Revision: 1.0
// ============================================================================
module pong_score_fsm #(
  parameter int GAME_WIDTH    = 40,
  parameter int GAME_HEIGHT   = 30,
  parameter int PADDLE_HEIGHT = 6,
  parameter int SCORE_LIMIT   = 9,
  parameter int SERVE_DELAY   = 25000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [5:0] ball_x,
  input  logic [5:0] ball_y,
  input  logic [5:0] p1_paddle_y,
  input  logic [5:0] p2_paddle_y,
  output logic       ball_run,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       point_pulse,
  output logic       game_over,
  output logic       winner
);

  if (SCORE_LIMIT < 1 || SCORE_LIMIT > 15 || GAME_WIDTH < 2 || GAME_WIDTH > 64 ||
      GAME_HEIGHT < 1 || GAME_HEIGHT > 64 || PADDLE_HEIGHT < 1 ||
      SERVE_DELAY < 1 || SERVE_DELAY > 33554432) begin : g_param_check
    $error("pong_score_fsm: parameter out of range");
  end

  localparam logic [6:0] PADDLE_SPAN = 7'(PADDLE_HEIGHT - 1);
  localparam logic [5:0] RIGHT_COL   = 6'(GAME_WIDTH - 1);
  localparam logic [3:0] LIMIT       = 4'(SCORE_LIMIT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUNNING   = 3'd1,
    POINT     = 3'd2,
    GAME_OVER = 3'd3
`ifdef PONG_AUTO_SERVE_EN
    , SERVE_WAIT = 3'd4
`endif
  } state_t;

  state_t     state;
  logic       start_prev;
  logic       scorer;       // 0 = P1 scored, 1 = P2 scored
  logic       start_edge;
  logic       hit_p1;
  logic       hit_p2;
  logic       miss_left;
  logic       miss_right;
  logic [3:0] scored_total;

`ifdef PONG_AUTO_SERVE_EN
  logic [24:0] serve_cnt;
`endif

  assign start_edge = start & ~start_prev;

  // Widened to 7 bits so a paddle hanging off the bottom edge cannot wrap.
  assign hit_p1 = ({1'b0, ball_y} >= {1'b0, p1_paddle_y}) &&
                  ({1'b0, ball_y} <= ({1'b0, p1_paddle_y} + PADDLE_SPAN));
  assign hit_p2 = ({1'b0, ball_y} >= {1'b0, p2_paddle_y}) &&
                  ({1'b0, ball_y} <= ({1'b0, p2_paddle_y} + PADDLE_SPAN));

  assign miss_left    = (ball_x == 6'd0) && !hit_p1;
  assign miss_right   = (ball_x == RIGHT_COL) && !hit_p2;
  assign scored_total = (scorer ? p2_score : p1_score) + 4'd1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      start_prev  <= 1'b1;
      scorer      <= 1'b0;
      ball_run    <= 1'b0;
      p1_score    <= 4'd0;
      p2_score    <= 4'd0;
      point_pulse <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
`ifdef PONG_AUTO_SERVE_EN
      serve_cnt   <= 25'd0;
`endif
    end else begin
      start_prev <= start;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= RUNNING;
            ball_run <= 1'b1;
          end
        end
        RUNNING: begin
          if (miss_left || miss_right) begin
            state       <= POINT;
            scorer      <= miss_left;
            ball_run    <= 1'b0;
            point_pulse <= 1'b1;
          end
        end
        POINT: begin
          point_pulse <= 1'b0;
          if (scorer) begin
            p2_score <= scored_total;
          end else begin
            p1_score <= scored_total;
          end
          if (scored_total == LIMIT) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
            winner    <= scorer;
          end else begin
`ifdef PONG_AUTO_SERVE_EN
            state     <= SERVE_WAIT;
            serve_cnt <= 25'd0;
`else
            state     <= IDLE;
`endif
          end
        end
        GAME_OVER: begin
          if (start_edge) begin
            state     <= IDLE;
            p1_score  <= 4'd0;
            p2_score  <= 4'd0;
            game_over <= 1'b0;
            winner    <= 1'b0;
          end
        end
`ifdef PONG_AUTO_SERVE_EN
        SERVE_WAIT: begin
          if (start_edge || serve_cnt == 25'(SERVE_DELAY - 1)) begin
            state    <= RUNNING;
            ball_run <= 1'b1;
          end else begin
            serve_cnt <= serve_cnt + 25'd1;
          end
        end
`endif
        default: begin
          state    <= IDLE;
          ball_run <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
